// File: rtl/dma_ch_sched_pkg.sv
// Shared types for the multi-channel DMA descriptor scheduler: FSM states,
// config register encodings and the channel descriptor record.
package dma_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_SRC  = 2'd0,
        REG_DST  = 2'd1,
        REG_LEN  = 2'd2,
        REG_CTRL = 2'd3
    } cfg_reg_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } desc_t;

    // Round-robin successor of channel idx among n channels.
    function automatic int next_ch(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dma_ch_sched_if.sv
// CPU config port, DMA engine port and channel status of the scheduler.
// slave = the scheduler, master = CPU/engine side driving it.
interface dma_ch_sched_if
    import dma_sched_pkg::*;
#(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    cfg_reg_t          cfg_reg;
    logic [31:0]       cfg_wdata;
    logic [NUM_CH-1:0] done_clr;

    logic              dma_en;
    logic [31:0]       dma_src;
    logic [31:0]       dma_dst;
    logic [31:0]       dma_len;
    logic              dma_done;

    logic [NUM_CH-1:0] ch_pend;
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_err;
    logic              irq;

    modport slave (
        input  cfg_we, cfg_ch, cfg_reg, cfg_wdata, done_clr, dma_done,
        output dma_en, dma_src, dma_dst, dma_len,
        output ch_pend, ch_busy, ch_done, ch_err, irq
    );

    modport master (
        output cfg_we, cfg_ch, cfg_reg, cfg_wdata, done_clr, dma_done,
        input  dma_en, dma_src, dma_dst, dma_len,
        input  ch_pend, ch_busy, ch_done, ch_err, irq
    );

endinterface

// File: rtl/dma_rr_arb.sv
// Combinational round-robin picker: first pending channel at or after rr_ptr,
// wrapping modulo NUM_CH.
module dma_rr_arb #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         pend,
    input  logic [$clog2(NUM_CH)-1:0] rr_ptr,
    output logic                      gnt_vld,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx
);

    localparam int CH_W = $clog2(NUM_CH);

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        int c;
        c       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // Scan from the farthest offset down so the nearest pending channel is written last and wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = int'(rr_ptr) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (pend[c[CH_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = c[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_ch_sched.sv
// Round-robin descriptor scheduler feeding a single-channel DMA engine.
// Define DMA_SCHED_TIMEOUT_EN to enable the per-transfer watchdog and ch_err flags.
module dma_ch_sched
    import dma_sched_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int TO_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    dma_ch_sched_if.slave bus
);

    localparam int CH_W = $clog2(NUM_CH);

    state_t            state, state_nxt;
    desc_t             desc [NUM_CH];
    desc_t             out_desc;
    logic [NUM_CH-1:0] pend, busy, done, err;
    logic [CH_W-1:0]   rr_ptr, cur_ch, gnt_idx, rr_after_gnt, rr_after_cur;
    logic              gnt_vld, zero_len, wd_expired;
    logic              do_grant, do_complete, do_timeout;
    logic              cfg_ok, dma_en_q, irq_q;

    dma_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .pend    (pend),
        .rr_ptr  (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign zero_len     = (desc[gnt_idx].len == 32'd0);
    assign rr_after_gnt = CH_W'(next_ch(int'(gnt_idx), NUM_CH));
    assign rr_after_cur = CH_W'(next_ch(int'(cur_ch), NUM_CH));
    // Writes to a pending or in-flight channel are dropped so a granted descriptor is never torn.
    assign cfg_ok = bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH)
                    && !pend[bus.cfg_ch] && !busy[bus.cfg_ch];

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (gnt_vld && !zero_len) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT:   if (bus.dma_done || wd_expired) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!bus.dma_done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        do_grant    = 1'b0;
        do_complete = 1'b0;
        do_timeout  = 1'b0;
        case (state)
            ST_IDLE: do_grant = gnt_vld;
            ST_WAIT: begin
                do_complete = bus.dma_done;
                do_timeout  = !bus.dma_done && wd_expired;
            end
            default: ;
        endcase
    end

    // NOTE: the descriptor array is reset because a zero descriptor is a defined, launchable state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) desc[c] <= '0;
        end else if (cfg_ok) begin
            case (bus.cfg_reg)
                REG_SRC: desc[bus.cfg_ch].src <= bus.cfg_wdata;
                REG_DST: desc[bus.cfg_ch].dst <= bus.cfg_wdata;
                REG_LEN: desc[bus.cfg_ch].len <= bus.cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            busy     <= '0;
            done     <= '0;
            rr_ptr   <= '0;
            cur_ch   <= '0;
            out_desc <= '0;
            dma_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            dma_en_q <= (state_nxt == ST_WAIT);
            irq_q    <= |(done | err);
            // Clear first; a same-cycle set below overrides it.
            done     <= done & ~bus.done_clr;
            if (cfg_ok && bus.cfg_reg == REG_CTRL && bus.cfg_wdata[0])
                pend[bus.cfg_ch] <= 1'b1;
            if (do_grant) begin
                pend[gnt_idx] <= 1'b0;
                cur_ch        <= gnt_idx;
                out_desc      <= desc[gnt_idx];
                if (zero_len) begin
                    done[gnt_idx] <= 1'b1;
                    rr_ptr        <= rr_after_gnt;
                end else begin
                    busy[gnt_idx] <= 1'b1;
                end
            end
            if (do_complete) done[cur_ch] <= 1'b1;
            if (do_complete || do_timeout) begin
                busy   <= '0;
                rr_ptr <= rr_after_cur;
            end
        end
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TO_CYCLES) + 1;
    logic [WD_W-1:0] wdog;

    assign wd_expired = (wdog == WD_W'(TO_CYCLES - 1));

    // Counter is zero on LAUNCH entry and counts every LAUNCH/WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE)                  wdog <= '0;
        else if (state == ST_LAUNCH || state == ST_WAIT) wdog <= wdog + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
        end else begin
            err <= err & ~bus.done_clr;
            if (do_timeout) err[cur_ch] <= 1'b1;
        end
    end
`else
    logic unused_to;
    assign unused_to  = ^TO_CYCLES;
    assign wd_expired = 1'b0;
    assign err        = '0;
`endif

    assign bus.dma_en  = dma_en_q;
    assign bus.dma_src = out_desc.src;
    assign bus.dma_dst = out_desc.dst;
    assign bus.dma_len = out_desc.len;
    assign bus.ch_pend = pend;
    assign bus.ch_busy = busy;
    assign bus.ch_done = done;
    assign bus.ch_err  = err;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_dma_ch_sched.sv
// Directed bench for dma_ch_sched: latency, round-robin order, write guards,
// boundary cases, reset mid-transfer and (with DMA_SCHED_TIMEOUT_EN) the watchdog.
module tb_dma_ch_sched;
    import dma_sched_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int TO_CYCLES = 64;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dma_ch_sched_if #(.NUM_CH(NUM_CH)) bus ();

    dma_ch_sched #(.NUM_CH(NUM_CH), .TO_CYCLES(TO_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

    // All stimulus is applied and all outputs sampled on the falling edge.
    task automatic cfg_write(input int ch, input cfg_reg_t r, input logic [31:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = ch[1:0];
        bus.cfg_reg   = r;
        bus.cfg_wdata = d;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
        bus.cfg_wdata = '0;
    endtask

    task automatic program_ch(input int ch, input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] len);
        cfg_write(ch, REG_SRC, src);
        cfg_write(ch, REG_DST, dst);
        cfg_write(ch, REG_LEN, len);
    endtask

    task automatic pulse_clr(input logic [3:0] mask);
        bus.done_clr = mask;
        @(negedge clk);
        bus.done_clr = '0;
    endtask

    task automatic wait_en(input string name, input int budget);
        int n;
        n = 0;
        while (bus.dma_en !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.dma_en !== 1'b1) begin
            errors++;
            $display("FAIL %s: dma_en=%b after %0d cycles, required 1", name, bus.dma_en, budget);
        end
    endtask

    // Waits for a launch, checks which descriptor is on the engine, then completes it.
    task automatic serve(input string name, input logic [3:0] exp_busy, input logic [31:0] exp_src,
                         input logic [31:0] exp_len, input bit hold);
        wait_en(name, 20);
        checks++;
        if (bus.ch_busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy: ch_busy=%b required %b", name, bus.ch_busy, exp_busy);
        end
        checks++;
        if (bus.dma_src !== exp_src) begin
            errors++;
            $display("FAIL %s src: dma_src=%h required %h", name, bus.dma_src, exp_src);
        end
        checks++;
        if (bus.dma_len !== exp_len) begin
            errors++;
            $display("FAIL %s len: dma_len=%h required %h", name, bus.dma_len, exp_len);
        end
        bus.dma_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b0 || bus.ch_busy !== 4'b0000) begin
            errors++;
            $display("FAIL %s complete: dma_en=%b ch_busy=%b required 0 0000", name, bus.dma_en, bus.ch_busy);
        end
        if (!hold) bus.dma_done = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.dma_en, bus.irq} !== 2'b00) begin
            errors++;
            $display("FAIL %s ctl: dma_en=%b irq=%b required 0 0", name, bus.dma_en, bus.irq);
        end
        checks++;
        if ({bus.dma_src, bus.dma_dst, bus.dma_len} !== 96'h0) begin
            errors++;
            $display("FAIL %s desc: src=%h dst=%h len=%h required 0", name, bus.dma_src, bus.dma_dst, bus.dma_len);
        end
        checks++;
        if ({bus.ch_pend, bus.ch_busy, bus.ch_done, bus.ch_err} !== 16'h0) begin
            errors++;
            $display("FAIL %s flags: pend=%b busy=%b done=%b err=%b required 0", name,
                     bus.ch_pend, bus.ch_busy, bus.ch_done, bus.ch_err);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_reg  = REG_SRC;
        bus.cfg_wdata = '0;
        bus.done_clr = '0;
        bus.dma_done = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        program_ch(0, 32'h1000, 32'h2000, 32'd16);
        cfg_write(0, REG_CTRL, 32'd1);
        checks++;
        if (bus.ch_pend !== 4'b0001 || bus.dma_en !== 1'b0) begin
            errors++;
            $display("FAIL single pend: ch_pend=%b dma_en=%b required 0001 0", bus.ch_pend, bus.dma_en);
        end
        @(negedge clk);
        checks++;
        if (bus.ch_busy !== 4'b0001 || bus.ch_pend !== 4'b0000 || bus.dma_en !== 1'b0) begin
            errors++;
            $display("FAIL single grant: busy=%b pend=%b dma_en=%b required 0001 0000 0",
                     bus.ch_busy, bus.ch_pend, bus.dma_en);
        end
        checks++;
        if (bus.dma_src !== 32'h1000 || bus.dma_dst !== 32'h2000 || bus.dma_len !== 32'd16) begin
            errors++;
            $display("FAIL single desc: src=%h dst=%h len=%h required 1000 2000 10",
                     bus.dma_src, bus.dma_dst, bus.dma_len);
        end
        @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b1) begin
            errors++;
            $display("FAIL single latency: dma_en=%b two cycles after start, required 1", bus.dma_en);
        end
        @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b1 || bus.ch_done !== 4'b0000) begin
            errors++;
            $display("FAIL single wait: dma_en=%b ch_done=%b required 1 0000", bus.dma_en, bus.ch_done);
        end
        bus.dma_done = 1'b1;
        @(negedge clk);
        bus.dma_done = 1'b0;
        checks++;
        if (bus.ch_done !== 4'b0001 || bus.dma_en !== 1'b0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL single done: ch_done=%b dma_en=%b irq=%b required 0001 0 0",
                     bus.ch_done, bus.dma_en, bus.irq);
        end
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL single irq_rise: irq=%b required 1", bus.irq);
        end
        pulse_clr(4'b0001);
        checks++;
        if (bus.ch_done !== 4'b0000 || bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL single clr: ch_done=%b irq=%b required 0000 1", bus.ch_done, bus.irq);
        end
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL single irq_fall: irq=%b required 0", bus.irq);
        end
    endtask

    task automatic test_round_robin();
        program_ch(1, 32'h1100, 32'h2100, 32'd8);
        program_ch(2, 32'h1200, 32'h2200, 32'd8);
        program_ch(3, 32'h1300, 32'h2300, 32'd4);
        // Run ch3 first so rr wraps to 0; queue the next starts while done is still high.
        cfg_write(3, REG_CTRL, 32'd1);
        serve("rr_prime_ch3", 4'b1000, 32'h1300, 32'd4, 1'b1);
        cfg_write(3, REG_CTRL, 32'd1);
        cfg_write(1, REG_CTRL, 32'd1);
        cfg_write(2, REG_CTRL, 32'd1);
        checks++;
        if (bus.ch_pend !== 4'b1110 || bus.dma_en !== 1'b0) begin
            errors++;
            $display("FAIL rr pend: ch_pend=%b dma_en=%b required 1110 0", bus.ch_pend, bus.dma_en);
        end
        bus.dma_done = 1'b0;
        serve("rr_first_ch1", 4'b0010, 32'h1100, 32'd8, 1'b0);
        serve("rr_second_ch2", 4'b0100, 32'h1200, 32'd8, 1'b0);
        serve("rr_third_ch3", 4'b1000, 32'h1300, 32'd4, 1'b1);
        cfg_write(1, REG_CTRL, 32'd1);
        cfg_write(0, REG_CTRL, 32'd1);
        checks++;
        if (bus.ch_pend !== 4'b0011) begin
            errors++;
            $display("FAIL rr pend2: ch_pend=%b required 0011", bus.ch_pend);
        end
        bus.dma_done = 1'b0;
        serve("rr_wrap_ch0", 4'b0001, 32'h1000, 32'd16, 1'b0);
        serve("rr_wrap_ch1", 4'b0010, 32'h1100, 32'd8, 1'b0);
        checks++;
        if (bus.ch_done !== 4'b1111) begin
            errors++;
            $display("FAIL rr done: ch_done=%b required 1111", bus.ch_done);
        end
    endtask

    task automatic test_guard();
        program_ch(1, 32'h1100, 32'h2100, 32'd12);
        cfg_write(1, REG_CTRL, 32'd1);
        wait_en("guard_launch", 10);
        cfg_write(1, REG_LEN, 32'd8);
        checks++;
        if (bus.dma_len !== 32'd12) begin
            errors++;
            $display("FAIL guard out_len: dma_len=%h required c", bus.dma_len);
        end
        cfg_write(1, REG_CTRL, 32'd1);
        checks++;
        if (bus.ch_pend !== 4'b0000) begin
            errors++;
            $display("FAIL guard restart: ch_pend=%b required 0000", bus.ch_pend);
        end
        bus.dma_done = 1'b1;
        @(negedge clk);
        bus.dma_done = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b0 || bus.ch_busy !== 4'b0000 || bus.ch_pend !== 4'b0000) begin
            errors++;
            $display("FAIL guard no_regrant: dma_en=%b busy=%b pend=%b required 0 0000 0000",
                     bus.dma_en, bus.ch_busy, bus.ch_pend);
        end
        cfg_write(1, REG_CTRL, 32'd1);
        serve("guard_stored_len", 4'b0010, 32'h1100, 32'd12, 1'b0);
    endtask

    task automatic test_zero_len();
        int en_seen;
        pulse_clr(4'b1111);
        checks++;
        if (bus.ch_done !== 4'b0000) begin
            errors++;
            $display("FAIL zlen clr: ch_done=%b required 0000", bus.ch_done);
        end
        program_ch(2, 32'h1200, 32'h2200, 32'd0);
        cfg_write(2, REG_CTRL, 32'd1);
        @(negedge clk);
        checks++;
        if (bus.ch_done !== 4'b0100 || bus.ch_busy !== 4'b0000 || bus.ch_pend !== 4'b0000
            || bus.dma_len !== 32'd0) begin
            errors++;
            $display("FAIL zlen grant: done=%b busy=%b pend=%b len=%h required 0100 0000 0000 0",
                     bus.ch_done, bus.ch_busy, bus.ch_pend, bus.dma_len);
        end
        en_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.dma_en !== 1'b0) en_seen++;
        end
        checks++;
        if (en_seen != 0) begin
            errors++;
            $display("FAIL zlen no_en: dma_en high %0d cycles, required 0", en_seen);
        end
    endtask

    task automatic test_clr_collision();
        pulse_clr(4'b0100);
        checks++;
        if (bus.ch_done !== 4'b0000) begin
            errors++;
            $display("FAIL coll pre: ch_done=%b required 0000", bus.ch_done);
        end
        cfg_write(2, REG_CTRL, 32'd1);
        bus.done_clr = 4'b0100;
        @(negedge clk);
        bus.done_clr = '0;
        checks++;
        if (bus.ch_done !== 4'b0100) begin
            errors++;
            $display("FAIL coll set_wins: ch_done=%b required 0100", bus.ch_done);
        end
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL coll irq: irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_done_held();
        int en_seen;
        pulse_clr(4'b1111);
        cfg_write(0, REG_CTRL, 32'd1);
        wait_en("held_launch", 10);
        bus.dma_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ch_done !== 4'b0001) begin
            errors++;
            $display("FAIL held first: ch_done=%b required 0001", bus.ch_done);
        end
        cfg_write(3, REG_CTRL, 32'd1);
        en_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.dma_en !== 1'b0) en_seen++;
        end
        checks++;
        if (en_seen != 0 || bus.ch_pend !== 4'b1000 || bus.ch_done !== 4'b0001) begin
            errors++;
            $display("FAIL held drain: en_cycles=%0d pend=%b done=%b required 0 1000 0001",
                     en_seen, bus.ch_pend, bus.ch_done);
        end
        bus.dma_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b0 || bus.ch_busy !== 4'b0000) begin
            errors++;
            $display("FAIL held gap1: dma_en=%b busy=%b required 0 0000", bus.dma_en, bus.ch_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b0 || bus.ch_busy !== 4'b1000) begin
            errors++;
            $display("FAIL held gap2: dma_en=%b busy=%b required 0 1000", bus.dma_en, bus.ch_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b1) begin
            errors++;
            $display("FAIL held relaunch: dma_en=%b required 1", bus.dma_en);
        end
        bus.dma_done = 1'b1;
        @(negedge clk);
        bus.dma_done = 1'b0;
        checks++;
        if (bus.ch_done !== 4'b1001 || bus.ch_err !== 4'b0000) begin
            errors++;
            $display("FAIL held final: ch_done=%b ch_err=%b required 1001 0000", bus.ch_done, bus.ch_err);
        end
    endtask

    task automatic test_reset_mid();
        cfg_write(1, REG_CTRL, 32'd1);
        wait_en("rstmid_launch", 10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
`ifdef DMA_SCHED_TIMEOUT_EN
        program_ch(0, 32'h3000, 32'h4000, 32'd4);
        program_ch(1, 32'h3100, 32'h4100, 32'd4);
        cfg_write(0, REG_CTRL, 32'd1);
        cfg_write(1, REG_CTRL, 32'd1);
        checks++;
        if (bus.ch_busy !== 4'b0001 || bus.ch_pend !== 4'b0010) begin
            errors++;
            $display("FAIL to grant: busy=%b pend=%b required 0001 0010", bus.ch_busy, bus.ch_pend);
        end
        @(negedge clk);
        repeat (62) @(negedge clk);
        checks++;
        if (bus.ch_err !== 4'b0000 || bus.dma_en !== 1'b1) begin
            errors++;
            $display("FAIL to early: ch_err=%b dma_en=%b at 63 cycles, required 0000 1", bus.ch_err, bus.dma_en);
        end
        @(negedge clk);
        checks++;
        if (bus.ch_err !== 4'b0001 || bus.dma_en !== 1'b0 || bus.ch_done !== 4'b0000
            || bus.ch_busy !== 4'b0000) begin
            errors++;
            $display("FAIL to fire: err=%b dma_en=%b done=%b busy=%b required 0001 0 0000 0000",
                     bus.ch_err, bus.dma_en, bus.ch_done, bus.ch_busy);
        end
        serve("to_next_ch1", 4'b0010, 32'h3100, 32'd4, 1'b0);
        pulse_clr(4'b0001);
        checks++;
        if (bus.ch_err !== 4'b0000) begin
            errors++;
            $display("FAIL to clr: ch_err=%b required 0000", bus.ch_err);
        end
`else
        program_ch(0, 32'h3000, 32'h4000, 32'd4);
        cfg_write(0, REG_CTRL, 32'd1);
        wait_en("nowd_launch", 10);
        repeat (70) @(negedge clk);
        checks++;
        if (bus.dma_en !== 1'b1 || bus.ch_busy !== 4'b0001 || bus.ch_err !== 4'b0000) begin
            errors++;
            $display("FAIL nowd unbounded: dma_en=%b busy=%b err=%b required 1 0001 0000",
                     bus.dma_en, bus.ch_busy, bus.ch_err);
        end
        bus.dma_done = 1'b1;
        @(negedge clk);
        bus.dma_done = 1'b0;
        checks++;
        if (bus.ch_done !== 4'b0001) begin
            errors++;
            $display("FAIL nowd done: ch_done=%b required 0001", bus.ch_done);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_guard();
        test_zero_len();
        test_clr_collision();
        test_done_held();
        test_reset_mid();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_ch_sched.md
# dma_ch_sched

Multi-channel descriptor scheduler in front of the single-channel DMA engine. The CPU-side slave programs up to NUM_CH channel descriptors (source, destination, length) and sets per-channel start bits. The block round-robin arbitrates among started channels and drives one descriptor at a time onto the engine's DMAEN/DMASRC/DMADST/DMALEN inputs. It waits for engine completion, then records per-channel done status and raises an aggregated interrupt to the CPU.

## Interface
- NUM_CH, 4: number of channels, 2..8.
- TO_CYCLES, 4096: watchdog limit in cycles. Used only when DMA_SCHED_TIMEOUT_EN is defined.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  descriptor write strobe, one cycle per write.
- cfg_ch  in  $clog2(NUM_CH)  target channel.
- cfg_reg  in  2  register select: 0=SRC, 1=DST, 2=LEN, 3=CTRL (bit0=start).
- cfg_wdata  in  32  write data.
- done_clr  in  NUM_CH  per-channel pulse that clears ch_done.
- dma_en  out  1  engine enable (maps to DMAEN).
- dma_src  out  32  maps to DMASRC.
- dma_dst  out  32  maps to DMADST.
- dma_len  out  32  maps to DMALEN.
- dma_done  in  1  engine completion (DMA_interrupt), level.
- ch_pend  out  NUM_CH  started and not yet granted.
- ch_busy  out  NUM_CH  one-hot of the channel on the engine, or 0.
- ch_done  out  NUM_CH  sticky completion flags.
- ch_err  out  NUM_CH  sticky timeout flags. Constant 0 without the macro.
- irq  out  1  registered OR of ch_done | ch_err.

## Operation
- Reset values: all outputs 0; descriptors 0; rr pointer 0; FSM IDLE.
- Descriptor writes:
  - A write to SRC/DST/LEN of channel c updates its register next edge, unless c is pending or busy; in that case the write is ignored.
  - CTRL write with bit0=1 sets pend[c] unless c is already pending or busy; in that case it is ignored.
  - CTRL write with bit0=0 has no effect.
- FSM states: IDLE, LAUNCH, WAIT, DRAIN.
  - IDLE, pend nonzero:
    - Grant the first pending channel at or after the rr pointer, modulo NUM_CH.
    - Latch its descriptor onto dma_src/dst/len, clear pend[g], set ch_busy[g].
    - If LEN==0: set ch_done[g], advance rr to g+1, stay IDLE, never assert dma_en.
    - Otherwise go to LAUNCH.
  - LAUNCH: dma_en=1; go to WAIT.
  - WAIT:
    - dma_en held 1 and descriptor outputs held stable.
    - On dma_done=1: dma_en=0, set ch_done[g], clear ch_busy, rr=g+1 mod NUM_CH, go to DRAIN.
  - DRAIN:
    - dma_en stays 0 until dma_done samples 0; then go to IDLE.
    - This guarantees a stale level-high done is never credited to the next grant.
- dma_done outside WAIT is ignored.
- If done_clr[c] and a set of ch_done[c] occur in the same cycle, the set wins.
- A start on the currently busy channel is ignored. Software re-arms the channel after ch_done.
- Reset mid-transfer: all state clears at the next edge and dma_en drops. The engine shares rst and is reset at the same edge. The interrupted transfer is neither marked done nor retried.

## Timing
- CTRL start write at edge t: pend visible after t.
- IDLE grant at edge t+1; LAUNCH asserts dma_en after edge t+2.
- Minimum start-to-dma_en latency: 2 cycles.
- Back-to-back: channel A's dma_done sampled at edge n. DRAIN lasts at least 1 cycle (DRAIN→IDLE at edge n+1 if done has fallen). Grant of the next channel occurs at the IDLE edge n+2; its dma_en rises after edge n+3. Minimum dma_en low gap: 3 cycles.
- irq is registered: it rises one cycle after the ch_done/ch_err set and falls one cycle after the last flag clears.
- Descriptor outputs change only at grant edges.

## Configuration
- DMA_SCHED_TIMEOUT_EN defined:
  - A watchdog counter starts at 0 on entry to LAUNCH and increments every cycle in LAUNCH/WAIT.
  - On reaching TO_CYCLES-1 without dma_done: set ch_err[g] (not ch_done), drop dma_en, clear busy, advance rr, go to DRAIN.
  - done_clr[c] also clears ch_err[c].
- Undefined: no counter, ch_err tied 0, WAIT is unbounded.

## Structure
- Package dma_sched_pkg:
  - FSM state enum.
  - cfg_reg encodings: REG_SRC, REG_DST, REG_LEN, REG_CTRL.
  - Channel descriptor struct: src, dst, len, all 32 bits.
- Sub-module dma_rr_arb:
  - Combinational.
  - Inputs: pend vector, rr pointer.
  - Outputs: grant valid, grant index.
- Everything else lives in dma_ch_sched.

## Test plan
- Single channel: ch0 SRC=0x1000, DST=0x2000, LEN=16, start → dma_en rises 2 cycles after the start write, with dma_src=0x1000 and dma_len=16. dma_done pulse → ch_done=0001, irq=1 one cycle later.
- Round-robin: start ch3, ch1, ch2 in the same window with rr=0 → grant order 1,2,3. Then start ch0 and ch1 with rr=0 → 0 first.
- Guard writes: write ch1 LEN=8 while ch1 is busy → dma_len stays unchanged and the stored LEN is unchanged. Start on busy ch1 → no second grant.
- Boundaries:
  - LEN=0 start → ch_done set, dma_en never asserts.
  - done_clr on the same cycle as a set → flag remains 1.
  - dma_done held high 5 cycles → one completion; next dma_en only after done falls.
- Timeout (DMA_SCHED_TIMEOUT_EN, TO_CYCLES=64): no dma_done → ch_err set 64 cycles after LAUNCH entry, dma_en=0, next channel granted. Reset asserted mid-WAIT → all outputs 0 the next cycle.
